id_stage: RTL and testbench
===========================

# id_stage

Registered, parametrised decode stage for the minirv core, sitting between instruction fetch and execute. Accepts fetched instructions over a valid/ready handshake, decodes the full RV32I base set (optionally RV32M), and holds decoded bundles in a DEPTH-entry FIFO so fetch and execute can stall independently. Illegal encodings and `ebreak` are reported as flags carried with the bundle, not as simulation aborts.

## Interface
- `DEPTH`, 2: decoded-bundle FIFO entries; power of two, ≥2.
- `PC_W`, 32: program-counter width carried alongside the instruction.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  drop all buffered bundles and the same-cycle input.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  instruction address.
- `out_valid`  out  1  head bundle valid.
- `out_ready`  in  1  execute consumes head.
- `out_pc`  out  PC_W  address of head instruction.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices (rd forced 0 when reg_write=0).
- `out_imm`  out  32  sign-extended immediate (I/S/B/U/J per format; 0 for R).
- `out_func3`  out  3  instr[14:12].
- `out_alu_op`  out  4  ALU operation code.
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each  control.
- `out_mem_len`  out  3  byte/half/word, signed/unsigned.
- `out_br`, `out_jal`, `out_jalr`, `out_lui`, `out_auipc`  out  1 each  class flags.
- `out_ebreak`, `out_illegal`  out  1 each  trap flags.

## Operation
- Push: `in_valid && in_ready && !flush`; bundle = decode(in_instr) plus in_pc, written at tail.
- Pop: `out_valid && out_ready && !flush`; head advances.
- `in_ready = (count < DEPTH)`; no combinational path from out_ready to in_ready.
- `out_valid = (count != 0)`; all out_* fields are the registered head entry.
- Decode: opcode instr[6:0]; opcode[1:0]≠2'b11 → illegal. Supported: LUI, AUIPC, JAL, JALR(f3=0), BRANCH(f3≠2,3), LOAD(LB/LH/LW/LBU/LHU), STORE(SB/SH/SW), OP-IMM (shift f7 checked), OP (f7 ∈ {0x00,0x20} per op), FENCE (nop), SYSTEM: exactly 0x00100073 → ebreak, 0x00000073 → ecall decoded as illegal in this generation.
- Illegal bundle: all control (reg_write, mem_*) forced 0, illegal=1; still flows in order.
- alu_op: ADD for loads/stores/JALR/AUIPC/JAL; SUB/compare ops for branches per func3.
- Pointers DEPTH-modular, wrap naturally; count is $clog2(DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged, both pointers advance.
- flush: count, pointers → 0 next edge; dominates push and pop.

## Timing
- Reset (async assert, sync-release assumed upstream): count=0, pointers=0, out_valid=0, all stored fields and out_* = 0, in_ready=1 from first cycle after reset.
- Latency: instruction pushed at edge N is visible on out_* after edge N (cycle N+1) if FIFO was empty.
- Throughput: one bundle/cycle sustained when out_ready held high.
- Reset mid-operation discards all entries immediately.
- out_* stable while out_valid && !out_ready.

## Configuration
- `ID_STAGE_RV32M_EN` defined: OP with f7=0x01 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to alu_op codes 8–15, reg_write=1.
- Undefined: those encodings set illegal=1.

## Structure
- Package `id_pkg`: alu_op constants, mem_len constants, opcode constants, decoded-bundle packed struct.
- Sub-module `id_decode_core`: purely combinational instr → bundle; id_stage wraps it with FIFO and handshake.

## Test plan
- Reset, push 0x00500093 (addi x1,x0,5) → next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=ADD, reg_write=1.
- Push 0x0040A103 then 0x002080A3 back-to-back, out_ready=1 → lw: mem_read=1, imm=4, mem_len=word; sb: mem_write=1, imm=1, rd=0, mem_len=byte, one per cycle.
- Push 0x123452B7, 0x00100073, 0x00000000 → lui imm=0x12345000; ebreak=1; illegal=1 with all control 0.
- Hold out_ready=0, push 3 instructions with DEPTH=2 → in_ready=0 after second; third accepted only after a pop; order preserved.
- Fill FIFO, assert flush with in_valid=1 → next cycle out_valid=0, count 0, flushed input never emerges.
- Push 0x02208033 (mul) → with ID_STAGE_RV32M_EN: alu_op=MUL, illegal=0; without: illegal=1.

Source files
------------

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared constants, bundle type and helpers for the id_stage decode block
// Contents: alu_op codes, mem_len codes, RV32 opcodes, immediate formats,
//           the decoded-bundle struct and the immediate/ALU helper functions.
package id_pkg;

    // ALU operation codes. XOR/OR/AND share ALU_LOGIC; execute selects the
    // logical function from func3 (100 xor, 110 or, 111 and), which leaves
    // codes 8..15 free for the M extension.
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_LOGIC  = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_MUL    = 4'd8;
    localparam logic [3:0] ALU_MULH   = 4'd9;
    localparam logic [3:0] ALU_MULHSU = 4'd10;
    localparam logic [3:0] ALU_MULHU  = 4'd11;
    localparam logic [3:0] ALU_DIV    = 4'd12;
    localparam logic [3:0] ALU_DIVU   = 4'd13;
    localparam logic [3:0] ALU_REM    = 4'd14;
    localparam logic [3:0] ALU_REMU   = 4'd15;

    // Memory access length; values match the load/store func3 encoding.
    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  func3;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_len;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        ebreak;
        logic        illegal;
    } id_bundle_t;

    // Opcode bits are never part of an immediate, so only instr[31:7] is passed.
    function automatic logic [31:0] imm_gen(input logic [31:7] ins, input imm_fmt_e fmt);
        case (fmt)
            FMT_I:   imm_gen = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm_gen = {ins[31:12], 12'h000};
            FMT_J:   imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm_gen = 32'h0;
        endcase
    endfunction

    // Base integer ALU op from func3; alt selects SUB/SRA.
    function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_base = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_base = ALU_SLL;
            3'd2:    alu_base = ALU_SLT;
            3'd3:    alu_base = ALU_SLTU;
            3'd5:    alu_base = alt ? ALU_SRA : ALU_SRL;
            default: alu_base = ALU_LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-side and execute-side handshake bundle of id_stage
// slave modport: the decode stage (takes in_*, out_ready; drives in_ready, out_*).
// master modport: the surrounding pipeline / testbench.
interface id_stage_if #(parameter int PC_W = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [31:0]     out_imm;
    logic [2:0]      out_func3;
    logic [3:0]      out_alu_op;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic [2:0]      out_mem_len;
    logic            out_br;
    logic            out_jal;
    logic            out_jalr;
    logic            out_lui;
    logic            out_auipc;
    logic            out_ebreak;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_func3, out_alu_op, out_reg_write, out_mem_read, out_mem_write,
               out_mem_len, out_br, out_jal, out_jalr, out_lui, out_auipc,
               out_ebreak, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_func3, out_alu_op, out_reg_write, out_mem_read, out_mem_write,
               out_mem_len, out_br, out_jal, out_jalr, out_lui, out_auipc,
               out_ebreak, out_illegal
    );
endinterface

// File: rtl/id_decode_core.sv
// rtl/id_decode_core.sv - combinational RV32I(+M) instruction -> decoded bundle
// Ports: instr (32-bit instruction word) in; bundle (id_bundle_t) out.
// Macro ID_STAGE_RV32M_EN: when defined, OP with func7=0x01 decodes the M ops.
module id_decode_core
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output id_bundle_t  bundle
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    imm_fmt_e   fmt;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    id_bundle_t b;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        b       = '0;
        fmt     = FMT_NONE;
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        b.func3 = f3;
        // Opcodes with instr[1:0] != 2'b11 never match an arm and stay illegal.
        case (opcode)
            OPC_LUI: begin
                legal = 1'b1; fmt = FMT_U; b.reg_write = 1'b1; b.lui = 1'b1;
            end
            OPC_AUIPC: begin
                legal = 1'b1; fmt = FMT_U; b.reg_write = 1'b1; b.auipc = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1; fmt = FMT_J; b.reg_write = 1'b1; b.jal = 1'b1;
            end
            OPC_JALR: begin
                legal = (f3 == 3'd0); fmt = FMT_I; use_rs1 = 1'b1;
                b.reg_write = 1'b1; b.jalr = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3); fmt = FMT_B;
                use_rs1 = 1'b1; use_rs2 = 1'b1; b.br = 1'b1;
                // beq/bne subtract; blt/bge and bltu/bgeu compare.
                b.alu_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
            end
            OPC_LOAD: begin
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7); fmt = FMT_I;
                use_rs1 = 1'b1; b.reg_write = 1'b1; b.mem_read = 1'b1; b.mem_len = f3;
            end
            OPC_STORE: begin
                legal = (f3 < 3'd3); fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                b.mem_write = 1'b1; b.mem_len = f3;
            end
            OPC_OP_IMM: begin
                fmt = FMT_I; use_rs1 = 1'b1; b.reg_write = 1'b1;
                // Only shifts constrain the upper immediate bits.
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 legal = 1'b1;
                b.alu_op = alu_base(f3, (f3 == 3'd5) && instr[30]);
            end
            OPC_OP: begin
                fmt = FMT_NONE; use_rs1 = 1'b1; use_rs2 = 1'b1; b.reg_write = 1'b1;
                if (f7 == 7'h00) begin
                    legal = 1'b1; b.alu_op = alu_base(f3, 1'b0);
                end else if (f7 == 7'h20) begin
                    legal = (f3 == 3'd0) || (f3 == 3'd5); b.alu_op = alu_base(f3, 1'b1);
                end else if (f7 == 7'h01) begin
`ifdef ID_STAGE_RV32M_EN
                    legal = 1'b1; b.alu_op = {1'b1, f3};
`else
                    legal = 1'b0;
`endif
                end
            end
            OPC_FENCE: legal = (f3 == 3'd0);
            OPC_SYSTEM: begin
                // ecall and every other SYSTEM encoding is illegal here.
                legal = (instr == INSTR_EBREAK); b.ebreak = legal;
            end
            default: legal = 1'b0;
        endcase
        b.imm = imm_gen(instr[31:7], fmt);
        b.rs1 = use_rs1 ? instr[19:15] : 5'd0;
        b.rs2 = use_rs2 ? instr[24:20] : 5'd0;
        b.rd  = b.reg_write ? instr[11:7] : 5'd0;
        if (!legal) begin
            b         = '0;
            b.func3   = f3;
            b.illegal = 1'b1;
        end
    end

    assign bundle = b;

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered decode stage: decoder + DEPTH-entry bundle FIFO
// Ports: clk, rst_n (async active-low), flush; io (id_stage_if.slave) carries
//        the fetch handshake (in_*) and the decoded head bundle (out_*).
// Macro ID_STAGE_RV32M_EN (via id_decode_core) enables RV32M decode.
module id_stage
    import id_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    id_stage_if.slave  io
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        id_bundle_t      b;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    id_bundle_t         dec;
    entry_t             head;
    logic               push;
    logic               pop;

    id_decode_core u_decode (
        .instr  (io.in_instr),
        .bundle (dec)
    );

    // in_ready depends only on registered count, never on out_ready.
    assign io.in_ready  = (count_q < CNT_W'(DEPTH));
    assign io.out_valid = (count_q != '0);
    assign push = io.in_valid && io.in_ready && !flush;
    assign pop  = io.out_valid && io.out_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q].pc = io.in_pc;
                mem_d[wr_ptr_q].b  = dec;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign io.out_pc        = head.pc;
    assign io.out_rs1       = head.b.rs1;
    assign io.out_rs2       = head.b.rs2;
    assign io.out_rd        = head.b.rd;
    assign io.out_imm       = head.b.imm;
    assign io.out_func3     = head.b.func3;
    assign io.out_alu_op    = head.b.alu_op;
    assign io.out_reg_write = head.b.reg_write;
    assign io.out_mem_read  = head.b.mem_read;
    assign io.out_mem_write = head.b.mem_write;
    assign io.out_mem_len   = head.b.mem_len;
    assign io.out_br        = head.b.br;
    assign io.out_jal       = head.b.jal;
    assign io.out_jalr      = head.b.jalr;
    assign io.out_lui       = head.b.lui;
    assign io.out_auipc     = head.b.auipc;
    assign io.out_ebreak    = head.b.ebreak;
    assign io.out_illegal   = head.b.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking scoreboard bench for id_stage (DEPTH=2)
// Honours ID_STAGE_RV32M_EN for the expected result of the mul vector.
module tb_id_stage;
    import id_pkg::*;

    localparam int PC_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    id_stage_if #(.PC_W(PC_W)) ifc ();

    id_stage #(.DEPTH(2), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        id_bundle_t  b;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t cur_exp;
    int vectors = 0;
    int miscompares = 0;

    // Hand-derived expected bundles for every instruction the bench issues.
    function automatic id_bundle_t exp_of(input logic [31:0] instr);
        id_bundle_t e;
        e = '0;
        e.func3 = instr[14:12];
        if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0 && instr[19:15] == 5'd0) begin
            // addi rd, x0, imm
            e.rd = instr[11:7];
            e.imm = {{20{instr[31]}}, instr[31:20]};
            e.reg_write = 1'b1;
        end else begin
            case (instr)
                32'h0040A103: begin e.rs1 = 5'd1; e.rd = 5'd2; e.imm = 32'd4;
                    e.reg_write = 1'b1; e.mem_read = 1'b1; e.mem_len = 3'd2; end
                32'h002080A3: begin e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd1;
                    e.mem_write = 1'b1; e.mem_len = 3'd0; end
                32'h123452B7: begin e.rd = 5'd5; e.imm = 32'h1234_5000;
                    e.reg_write = 1'b1; e.lui = 1'b1; end
                32'h00100073: e.ebreak = 1'b1;
                32'h00000000: e.illegal = 1'b1;
                32'h00208463: begin e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd8;
                    e.alu_op = 4'd1; e.br = 1'b1; end
                32'h0020C463: begin e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd8;
                    e.alu_op = 4'd3; e.br = 1'b1; end
                32'h010000EF: begin e.rd = 5'd1; e.imm = 32'd16;
                    e.reg_write = 1'b1; e.jal = 1'b1; end
                32'h402081B3: begin e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3;
                    e.alu_op = 4'd1; e.reg_write = 1'b1; end
`ifdef ID_STAGE_RV32M_EN
                32'h02208033: begin e.rs1 = 5'd1; e.rs2 = 5'd2;
                    e.alu_op = 4'd8; e.reg_write = 1'b1; end
`else
                32'h02208033: e.illegal = 1'b1;
`endif
                default: e = '1;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input sb_item_t exp);
        sb_item_t o;
        o.pc = ifc.out_pc;
        o.b.rs1 = ifc.out_rs1;             o.b.rs2 = ifc.out_rs2;
        o.b.rd = ifc.out_rd;               o.b.imm = ifc.out_imm;
        o.b.func3 = ifc.out_func3;         o.b.alu_op = ifc.out_alu_op;
        o.b.reg_write = ifc.out_reg_write; o.b.mem_read = ifc.out_mem_read;
        o.b.mem_write = ifc.out_mem_write; o.b.mem_len = ifc.out_mem_len;
        o.b.br = ifc.out_br;               o.b.jal = ifc.out_jal;
        o.b.jalr = ifc.out_jalr;           o.b.lui = ifc.out_lui;
        o.b.auipc = ifc.out_auipc;         o.b.ebreak = ifc.out_ebreak;
        o.b.illegal = ifc.out_illegal;
        vectors++;
        assert (o === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        ifc.in_valid = 1'b1;
        ifc.in_instr = instr;
        ifc.in_pc = pc;
        cur_exp.pc = pc;
        cur_exp.b = exp_of(instr);
    endtask

    // One clock: compare popped head against the scoreboard, then advance.
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_push = ifc.in_valid && ifc.in_ready && !flush;
        do_pop = ifc.out_valid && ifc.out_ready && !flush;
        if (do_pop) begin
            vectors++;
            assert (sb_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_underflow observed=pop expected=no_pop");
            end
            if (sb_q.size() != 0) check_head("pop", sb_q.pop_front());
        end
        if (flush) sb_q.delete();
        @(posedge clk);
        #1;
        if (do_push) sb_q.push_back(cur_exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("drain_out_valid", 32'(ifc.out_valid), 32'd0);
    endtask

    logic [31:0] stream_a [3] = '{32'h123452B7, 32'h00100073, 32'h00000000};
    logic [31:0] stream_b [6] = '{32'h00208463, 32'h0020C463, 32'h010000EF,
                                  32'h402081B3, 32'h02208033, 32'hFFF00193};

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_instr = '0;
        ifc.in_pc = '0;
        ifc.out_ready = 1'b0;
        cur_exp = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check_head("rst_head", '0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

        // addi x1,x0,5: visible the cycle after the push.
        drive(32'h00500093, 32'h100);
        tick();
        ifc.in_valid = 1'b0;
        check("addi_out_valid", 32'(ifc.out_valid), 32'd1);
        check("addi_sb_size", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) check_head("addi_head", sb_q[0]);
        ifc.out_ready = 1'b1;
        tick();
        check("addi_popped", 32'(ifc.out_valid), 32'd0);

        // lw then sb back to back, one bundle per cycle.
        drive(32'h0040A103, 32'h104);
        tick();
        check("lw_out_valid", 32'(ifc.out_valid), 32'd1);
        drive(32'h002080A3, 32'h108);
        tick();
        check("tput_in_ready", 32'(ifc.in_ready), 32'd1);
        check("tput_out_valid", 32'(ifc.out_valid), 32'd1);
        ifc.in_valid = 1'b0;
        drain();

        // lui, ebreak, all-zero word.
        foreach (stream_a[i]) begin
            drive(stream_a[i], 32'h200 + 32'(i) * 4);
            tick();
        end
        ifc.in_valid = 1'b0;
        drain();

        // Backpressure with DEPTH=2: third accepted only after a pop.
        ifc.out_ready = 1'b0;
        drive(32'h00100113, 32'h300);
        tick();
        drive(32'h00200193, 32'h304);
        tick();
        check("full_in_ready", 32'(ifc.in_ready), 32'd0);
        drive(32'h00300213, 32'h308);
        tick();
        tick();
        check("stall_in_ready", 32'(ifc.in_ready), 32'd0);
        check("stall_sb_size", 32'(sb_q.size()), 32'd2);
        if (sb_q.size() != 0) check_head("stall_head", sb_q[0]);
        ifc.out_ready = 1'b1;
        tick();
        check("after_pop_in_ready", 32'(ifc.in_ready), 32'd1);
        tick();
        ifc.in_valid = 1'b0;
        drain();

        // Flush of a full FIFO with a pending input.
        ifc.out_ready = 1'b0;
        drive(32'h00400293, 32'h400);
        tick();
        drive(32'h00500313, 32'h404);
        tick();
        drive(32'h00100113, 32'h408);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        check("flush_out_valid", 32'(ifc.out_valid), 32'd0);
        check("flush_in_ready", 32'(ifc.in_ready), 32'd1);
        // Flush dominates a push the stage could otherwise accept.
        drive(32'h00200193, 32'h40C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ifc.in_valid = 1'b0;
        check("flush_push_out_valid", 32'(ifc.out_valid), 32'd0);
        drive(32'h00300213, 32'h410);
        tick();
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        drain();

        // Branches, jal, sub, mul, negative immediate under random backpressure.
        foreach (stream_b[i]) begin
            bit accepted;
            drive(stream_b[i], 32'h500 + 32'(i) * 4);
            accepted = 1'b0;
            for (int t = 0; t < 20 && !accepted; t++) begin
                ifc.out_ready = 1'($urandom_range(0, 1));
                accepted = ifc.in_ready;
                tick();
            end
            check("stream_b_accept", 32'(accepted), 32'd1);
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-operation discards entries at once.
        ifc.out_ready = 1'b0;
        drive(32'h00100113, 32'h600);
        tick();
        ifc.in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(ifc.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("async_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check_head("async_rst_head", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_release_in_ready", 32'(ifc.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
